// File: rtl/io_clk_p.sv
`default_nettype none
// ============================================================================
// Module      : io_clk_p (package)
// Description : Constants and types shared by the clock-recovery front end
//               and the word deserializer that consumes its events.
// Revision    : 1.0 - initial release
// ============================================================================
package io_clk_p;

    // Clock-recovery timing constants (in bit periods / oversample ticks).
    localparam int CR_OVERSAMPLE       = 16;
    localparam int CR_SHORT_PAUSE_BITS = 2;
    localparam int CR_LONG_PAUSE_BITS  = 6;

    // Deserializer defaults.
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_FIFO_DEPTH  = 4;

    // Deserializer framing state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sys_structs.sv
`default_nettype none
// ============================================================================
// Module      : sys_structs (package)
// Description : Shared system-level types. clk_domain bundles the single
//               clock with its clock enable and synchronous reset so that a
//               block's clocking travels through one port.
//                 clk      - the only clock of the domain
//                 clk_en   - state advances only when high
//                 sync_rst - synchronous, active-high reset (ignores clk_en)
// Revision    : 1.0 - initial release
// ============================================================================
package sys_structs;

    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_domain;

endpackage
`default_nettype wire

// File: rtl/rx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_fifo
// Description : Small synchronous FIFO of {first, last, data} entries for the
//               word deserializer. Registered not-empty flag, no bypass, so a
//               push into an empty FIFO becomes visible one cycle later.
//               A push into a full FIFO is discarded with a one-cycle drop
//               pulse unless a pop happens in the same cycle.
// Ports       :
//   sys_dom_i   in   clock / clock enable / synchronous reset bundle
//   push        in   write request
//   push_first  in   first-of-frame flag for the written word
//   push_last   in   last-of-frame flag for the written word
//   push_data   in   word to write
//   pop_ready   in   consumer ready; pop = valid && pop_ready
//   head_data   out  head word (zero while empty)
//   head_first  out  head first flag (zero while empty)
//   head_last   out  head last flag (zero while empty)
//   valid       out  registered not-empty flag
//   drop        out  one-cycle pulse when a push was lost to a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_fifo
    import io_clk_p::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  sys_structs::clk_domain  sys_dom_i,
    input  logic                    push,
    input  logic                    push_first,
    input  logic                    push_last,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop_ready,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic                    head_first,
    output logic                    head_last,
    output logic                    valid,
    output logic                    drop
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_idx_w = c_ptr_w - 1;
    localparam int c_ent_w = DATA_WIDTH + 2;

    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               r_valid;
    logic               r_drop;

    logic               w_en;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_drop;
    logic [c_ptr_w-1:0] w_wr_next;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_ent_w-1:0] w_head;

    assign w_en      = sys_dom_i.clk_en;
    // Extra pointer MSB distinguishes full from empty when indices match.
    assign w_full    = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                       (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);
    assign w_do_pop  = w_en & r_valid & pop_ready;
    // At full, a simultaneous pop frees the slot being written.
    assign w_do_push = w_en & push & (~w_full | w_do_pop);
    assign w_drop    = w_en & push & w_full & ~w_do_pop;
    assign w_wr_next = r_wr_ptr + {{(c_ptr_w-1){1'b0}}, w_do_push};
    assign w_rd_next = r_rd_ptr + {{(c_ptr_w-1){1'b0}}, w_do_pop};

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_valid  <= (w_wr_next != w_rd_next);
            r_drop   <= w_drop;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge sys_dom_i.clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_idx_w-1:0]] <= {push_first, push_last, push_data};
        end
    end

    assign w_head     = r_valid ? r_mem[r_rd_ptr[c_idx_w-1:0]] : '0;
    assign head_first = w_head[c_ent_w-1];
    assign head_last  = w_head[c_ent_w-2];
    assign head_data  = w_head[DATA_WIDTH-1:0];
    assign valid      = r_valid;
    assign drop       = r_drop;

endmodule
`default_nettype wire

// File: rtl/rx_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_deserializer
// Description : Assembles MSB-first bit ticks from clock recovery into words,
//               uses pause events for word/frame delimiting, and buffers the
//               words with first/last-of-frame flags in a small FIFO.
//               A completed word is held pending after its short pause; the
//               next tick pushes it as a middle word, a long pause pushes it
//               as the last word of the frame.
// Ports       :
//   sys_dom_i      in   clock / clock enable / synchronous reset bundle
//   rx_enable_i    in   deserializer enable (low forces IDLE)
//   data_i         in   recovered data bit, valid with tick_input_i
//   tick_input_i   in   one-cycle bit-sample strobe
//   pause_start_i  in   one-cycle pulse: line went quiet
//   short_pause_i  in   one-cycle pulse: pause reached word-gap length
//   long_pause_i   in   one-cycle pulse: pause reached frame-gap length
//   violation_i    in   clock-recovery timing violation
//   word_o         out  FIFO head data
//   word_first_o   out  head word is first of its frame
//   word_last_o    out  head word is last of its frame
//   word_valid_o   out  FIFO not empty (registered)
//   word_ready_i   in   consumer ready
//   frame_error_o  out  one-cycle pulse when a frame is abandoned
//   drop_o         out  one-cycle pulse when a word is lost to a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_deserializer
    import io_clk_p::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  sys_structs::clk_domain  sys_dom_i,
    input  logic                    rx_enable_i,
    input  logic                    data_i,
    input  logic                    tick_input_i,
    input  logic                    pause_start_i,
    input  logic                    short_pause_i,
    input  logic                    long_pause_i,
    input  logic                    violation_i,
    output logic [DATA_WIDTH-1:0]   word_o,
    output logic                    word_first_o,
    output logic                    word_last_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i,
    output logic                    frame_error_o,
    output logic                    drop_o
);

    localparam int                 c_cnt_w    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_WIDTH);

    rx_state_e               r_state;
    logic [c_cnt_w-1:0]      r_bit_count;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_pend_valid;
    logic [DATA_WIDTH-1:0]   r_pend_data;
    logic                    r_first_pending;
    logic                    r_frame_error;

    rx_state_e               w_state_nxt;
    logic [c_cnt_w-1:0]      w_bit_count_nxt;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic                    w_pend_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_pend_data_nxt;
    logic                    w_first_pending_nxt;
    logic                    w_push;
    logic                    w_push_last;
    logic                    w_enter_discard;

    always_comb begin
        w_state_nxt         = r_state;
        w_bit_count_nxt     = r_bit_count;
        w_shift_nxt         = r_shift;
        w_pend_valid_nxt    = r_pend_valid;
        w_pend_data_nxt     = r_pend_data;
        w_first_pending_nxt = r_first_pending;
        w_push              = 1'b0;
        w_push_last         = 1'b0;

        if (!rx_enable_i) begin
            w_state_nxt         = ST_IDLE;
            w_bit_count_nxt     = '0;
            w_shift_nxt         = '0;
            w_pend_valid_nxt    = 1'b0;
            w_pend_data_nxt     = '0;
            w_first_pending_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (long_pause_i) begin
                        w_state_nxt         = ST_RECEIVE;
                        w_first_pending_nxt = 1'b1;
                        w_bit_count_nxt     = '0;
                        w_shift_nxt         = '0;
                    end
                end

                ST_RECEIVE, ST_PAUSE: begin
                    // Violation outranks everything, including a push.
                    if (violation_i) begin
                        w_state_nxt      = ST_DISCARD;
                        w_bit_count_nxt  = '0;
                        w_shift_nxt      = '0;
                        w_pend_valid_nxt = 1'b0;
                        w_pend_data_nxt  = '0;
                    end else if (long_pause_i) begin
                        // Frame boundary: flush the pending word as last,
                        // then arm the next frame.
                        w_push              = r_pend_valid;
                        w_push_last         = 1'b1;
                        w_state_nxt         = ST_RECEIVE;
                        w_first_pending_nxt = 1'b1;
                        w_bit_count_nxt     = '0;
                        w_shift_nxt         = '0;
                        w_pend_valid_nxt    = 1'b0;
                        w_pend_data_nxt     = '0;
                    end else if (r_state == ST_RECEIVE) begin
                        if (tick_input_i) begin
                            if (r_bit_count == c_cnt_full) begin
                                w_state_nxt      = ST_DISCARD;
                                w_bit_count_nxt  = '0;
                                w_shift_nxt      = '0;
                                w_pend_valid_nxt = 1'b0;
                                w_pend_data_nxt  = '0;
                            end else begin
                                w_shift_nxt     = {r_shift[DATA_WIDTH-2:0], data_i};
                                w_bit_count_nxt = r_bit_count + 1'b1;
                                // First bit of a new word releases the
                                // previous one as a middle word.
                                if (r_pend_valid) begin
                                    w_push              = 1'b1;
                                    w_pend_valid_nxt    = 1'b0;
                                    w_first_pending_nxt = 1'b0;
                                end
                            end
                        end else if (pause_start_i) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end else begin
                        if (short_pause_i) begin
                            if (r_bit_count == c_cnt_full && !r_pend_valid) begin
                                w_pend_valid_nxt = 1'b1;
                                w_pend_data_nxt  = r_shift;
                                w_bit_count_nxt  = '0;
                                w_state_nxt      = ST_RECEIVE;
                            end else begin
                                w_state_nxt      = ST_DISCARD;
                                w_bit_count_nxt  = '0;
                                w_shift_nxt      = '0;
                                w_pend_valid_nxt = 1'b0;
                                w_pend_data_nxt  = '0;
                            end
                        end
                    end
                end

                ST_DISCARD: begin
                    if (long_pause_i) begin
                        w_state_nxt         = ST_RECEIVE;
                        w_first_pending_nxt = 1'b1;
                        w_bit_count_nxt     = '0;
                        w_shift_nxt         = '0;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_enter_discard = (w_state_nxt == ST_DISCARD) && (r_state != ST_DISCARD);

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            r_state         <= ST_IDLE;
            r_bit_count     <= '0;
            r_shift         <= '0;
            r_pend_valid    <= 1'b0;
            r_pend_data     <= '0;
            r_first_pending <= 1'b0;
            r_frame_error   <= 1'b0;
        end else begin
            // Pulse lasts one clk cycle even when clk_en is low afterwards.
            r_frame_error <= sys_dom_i.clk_en & w_enter_discard;
            if (sys_dom_i.clk_en) begin
                r_state         <= w_state_nxt;
                r_bit_count     <= w_bit_count_nxt;
                r_shift         <= w_shift_nxt;
                r_pend_valid    <= w_pend_valid_nxt;
                r_pend_data     <= w_pend_data_nxt;
                r_first_pending <= w_first_pending_nxt;
            end
        end
    end

    assign frame_error_o = r_frame_error;

    rx_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_dom_i  (sys_dom_i),
        .push       (w_push),
        .push_first (r_first_pending),
        .push_last  (w_push_last),
        .push_data  (r_pend_data),
        .pop_ready  (word_ready_i),
        .head_data  (word_o),
        .head_first (word_first_o),
        .head_last  (word_last_o),
        .valid      (word_valid_o),
        .drop       (drop_o)
    );

endmodule
`default_nettype wire
